// File: rtl/seg7_scan_rx.sv
// Reader for a multiplexed common-anode 7-segment bus: synchronizes, qualifies and decodes each
// strobed digit and emits whole frames. Define SEG7_SCAN_RX_DP_EN to capture the decimal points.
module seg7_scan_rx #(
  parameter int NUM_DIGITS  = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  output logic [4*NUM_DIGITS-1:0]   digits_out,
  output logic                      frame_valid,
  output logic [NUM_DIGITS-1:0]     digit_err,
  output logic [NUM_DIGITS-1:0]     blank,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic                      stale
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    logic [5:0] r; // {blank, err, value}
    r = {2'b01, 4'hE};
    case (s)
      7'b1000000: r = {2'b00, 4'd0};
      7'b1111001: r = {2'b00, 4'd1};
      7'b0100100: r = {2'b00, 4'd2};
      7'b0110000: r = {2'b00, 4'd3};
      7'b0011001: r = {2'b00, 4'd4};
      7'b0010010: r = {2'b00, 4'd5};
      7'b0000010: r = {2'b00, 4'd6};
      7'b1111000: r = {2'b00, 4'd7};
      7'b0000000: r = {2'b00, 4'd8};
      7'b0010000: r = {2'b00, 4'd9};
      7'b1111111: r = {2'b10, 4'hF};
      default:    r = {2'b01, 4'hE};
    endcase
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synchronized sample for change detection.
  logic [7:0]            seg_p0, seg_p1, seg_p2;
  logic [NUM_DIGITS-1:0] an_p0, an_p1, an_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0 <= '1;
      seg_p1 <= '1;
      seg_p2 <= '1;
      an_p0  <= '1;
      an_p1  <= '1;
      an_p2  <= '1;
    end else begin
      seg_p0 <= seg_in;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
      an_p0  <= an_in;
      an_p1  <= an_p0;
      an_p2  <= an_p1;
    end
  end

  // Stage p1 qualification: exactly one active-low strobe is a digit.
  logic [NUM_DIGITS-1:0] an_low;
  logic                  an_ok, an_chg, seg_chg;
  logic [IDX_W-1:0]      an_idx;
  logic [5:0]            dec;

  assign an_low  = ~an_p1;
  assign an_ok   = (an_low != '0) && ((an_low & (an_low - AN_ONE)) == '0);
  assign an_chg  = (an_p1 != an_p2);
  assign seg_chg = (seg_p1 != seg_p2);
  assign dec     = seg_decode(seg_p1[6:0]);

  always_comb begin
    an_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (!an_p1[k]) an_idx = IDX_W'(k);
  end

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             cap;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (an_ok) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
          idx_nxt   = an_idx;
        end
      end
      SETTLE: begin
        if (an_chg || seg_chg) begin
          state_nxt = an_ok ? SETTLE : IDLE;
          cnt_nxt   = '0;
          idx_nxt   = an_idx;
        end else if (cnt == CNT_LAST) begin
          cap       = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HOLD: begin
        // Segment changes while the same anode stays lit must not re-capture.
        if (an_chg) begin
          state_nxt = an_ok ? SETTLE : IDLE;
          cnt_nxt   = '0;
          idx_nxt   = an_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: slot write; the completing capture is merged before the frame is copied out.
  logic [4*NUM_DIGITS-1:0] slot_val, slot_val_nxt;
  logic [NUM_DIGITS-1:0]   slot_err, slot_err_nxt, slot_blank, slot_blank_nxt;
  logic [NUM_DIGITS-1:0]   mask, mask_nxt;
  logic                    frame_done;
  logic [TMO_W-1:0]        tmo;

  always_comb begin
    slot_val_nxt   = slot_val;
    slot_err_nxt   = slot_err;
    slot_blank_nxt = slot_blank;
    mask_nxt       = mask;
    if (cap) begin
      slot_val_nxt[4*idx +: 4] = dec[3:0];
      slot_err_nxt[idx]        = dec[4];
      slot_blank_nxt[idx]      = dec[5];
      mask_nxt[idx]            = 1'b1;
    end
  end

  assign frame_done = cap && (mask_nxt == '1);
  assign stale      = (tmo == '0);

  always_ff @(posedge clk) begin
    slot_val   <= slot_val_nxt;
    slot_err   <= slot_err_nxt;
    slot_blank <= slot_blank_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      mask        <= '0;
      tmo         <= TMO_RELOAD;
      frame_valid <= 1'b0;
      digits_out  <= '0;
      digit_err   <= '0;
      blank       <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_valid <= frame_done;
      if (frame_done) begin
        mask       <= '0;
        tmo        <= TMO_RELOAD;
        digits_out <= slot_val_nxt;
        digit_err  <= slot_err_nxt;
        blank      <= slot_blank_nxt;
      end else begin
        mask <= mask_nxt;
        if (tmo != '0) tmo <= tmo - TMO_W'(1);
      end
    end
  end

`ifdef SEG7_SCAN_RX_DP_EN
  logic [NUM_DIGITS-1:0] slot_dp, slot_dp_nxt;

  always_comb begin
    slot_dp_nxt = slot_dp;
    if (cap) slot_dp_nxt[idx] = ~seg_p1[7];
  end

  always_ff @(posedge clk) slot_dp <= slot_dp_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dp_out <= '0;
    else if (frame_done) dp_out <= slot_dp_nxt;
  end
`else
  assign dp_out = '0;
`endif

endmodule
